// File: rtl/hit_judge_if.sv
// hit_judge_if: game-state, note and button inputs plus the hit/miss/combo outputs of the hit judge.
interface hit_judge_if;
   logic [1:0] current_state;
   logic [1:0] note_pulse;
   logic [1:0] btn;
   logic [1:0] hit;
   logic       miss;
   logic [7:0] combo;
   logic [7:0] max_combo;
   modport master (output current_state, note_pulse, btn, input hit, miss, combo, max_combo);
   modport slave (input current_state, note_pulse, btn, output hit, miss, combo, max_combo);
endinterface

// File: rtl/hit_judge.sv
// hit_judge: two-lane timing-window judge producing hit/miss pulses and a saturating combo count.
module hit_judge #(
   parameter int WINDOW = 12,
   parameter int WIN_W  = 8
) (
   input logic        clk,
   input logic        rst,
   hit_judge_if.slave jb
);
   typedef enum logic {L_IDLE, L_ARMED} lane_t;
   localparam logic [WIN_W-1:0] RELOAD = WIN_W'(WINDOW - 1);
   lane_t            lane_q [2];
   lane_t            lane_d [2];
   logic [WIN_W-1:0] cnt_q [2];
   logic [WIN_W-1:0] cnt_d [2];
   logic [1:0]       btn_q, press, hit_d, hit_q, miss_l;
   logic             miss_d, miss_q, play, sel;
   logic [7:0]       combo_d, combo_q, max_d, max_q;
   logic [8:0]       sum;
   always_comb begin
      play  = jb.current_state == 2'd2;
      sel   = jb.current_state == 2'd1;
      press = jb.btn & ~btn_q;
      for (int i = 0; i < 2; i++) begin
         hit_d[i]  = play && lane_q[i] == L_ARMED && press[i];
         miss_l[i] = play && lane_q[i] == L_ARMED && !press[i] && (jb.note_pulse[i] || cnt_q[i] == '0);
         lane_d[i] = lane_q[i];
         cnt_d[i]  = cnt_q[i];
         // a new note always (re)arms, whether the old one was hit, missed or absent
         if (!play) begin
            lane_d[i] = L_IDLE;
            cnt_d[i]  = '0;
         end else if (jb.note_pulse[i]) begin
            lane_d[i] = L_ARMED;
            cnt_d[i]  = RELOAD;
         end else if (lane_q[i] == L_ARMED) begin
            if (press[i] || cnt_q[i] == '0) lane_d[i] = L_IDLE;
            else cnt_d[i] = cnt_q[i] - WIN_W'(1);
         end
      end
      miss_d  = |miss_l;
      sum     = {1'b0, combo_q} + 9'(hit_d[0]) + 9'(hit_d[1]);
      combo_d = (sel || miss_d) ? 8'd0 : play ? (sum[8] ? 8'hff : sum[7:0]) : combo_q;
      max_d   = sel ? 8'd0 : (combo_d > max_q ? combo_d : max_q);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q  <= '{L_IDLE, L_IDLE};
         cnt_q   <= '{'0, '0};
         btn_q   <= '0;
         hit_q   <= '0;
         miss_q  <= 1'b0;
         combo_q <= '0;
         max_q   <= '0;
      end else begin
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         btn_q   <= jb.btn;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         combo_q <= combo_d;
         max_q   <= max_d;
      end
   end
   assign jb.hit       = hit_q;
   assign jb.miss      = miss_q;
   assign jb.combo     = combo_q;
   assign jb.max_combo = max_q;
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Producer side of the scoring interface: turns note-arrival pulses and player buttons into the per-cycle 2-bit hit vector and the 8-bit combo count that the score counter consumes.
- Two lanes. Each lane opens a timing window when a note reaches the hit line and judges it hit or miss.
- Active only in GAME_PLAY. Cleared in SONG_SELECT.

Parameters:
- WINDOW, 12, hit window length in clock cycles (1..255).
- WIN_W, 8, width of the per-lane window counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- current_state  in  2  game state: 0 IDLE, 1 SONG_SELECT, 2 GAME_PLAY, 3 GAME_OVER
- note_pulse  in  2  one-cycle pulse per lane, asserted when a note reaches the hit line
- btn  in  2  debounced, synchronized lane buttons (level)
- hit  out  2  one-cycle pulse per lane on a judged hit; drives the scorer's Inp
- miss  out  1  one-cycle pulse when any lane misses in that cycle
- combo  out  8  current consecutive-hit count, saturating
- max_combo  out  8  highest combo reached since the last clear

Behaviour:
- Reset (async, rst=1): hit=0, miss=0, combo=0, max_combo=0, btn_q=0, both lanes L_IDLE, counters=0.
- Edge detect: btn_q<=btn every cycle. press[i]=btn[i]&~btn_q[i]. Only rising edges count; holding a button never produces a second hit.
- Per-lane FSM (updated only when current_state==GAME_PLAY):
  - L_IDLE: note_pulse -> L_ARMED, cnt<=WINDOW-1. press is ignored (no penalty).
  - L_ARMED, priority order:
    - (a) press -> hit for the pending note.
    - (b) else note_pulse -> miss for the old note; re-arm, cnt<=WINDOW-1.
    - (c) else cnt==0 -> miss, go to L_IDLE.
    - (d) else cnt<=cnt-1.
  - L_ARMED with press and note_pulse in the same cycle -> hit for the old note, stay L_ARMED, cnt<=WINDOW-1.
  - After a hit without a new note_pulse -> L_IDLE.
  - The window therefore accepts a press in exactly WINDOW consecutive cycles, starting the cycle after note_pulse.
- Latency: a press or timeout judged in cycle N gives registered hit[i]/miss high in cycle N+1 only. combo and max_combo update in the same N+1 edge.
- Combo arithmetic, per cycle, from that cycle's judgements:
  - Any miss -> combo<=0. Miss dominates a hit on the other lane in the same cycle; hit[i] still pulses.
  - Else combo<=min(combo+popcount(hits),255). Both lanes hitting adds 2; 254+2 -> 255.
  - max_combo<=max(max_combo, new combo).
- State handling:
  - SONG_SELECT: combo=0, max_combo=0, lanes forced to L_IDLE, cnt=0, hit=0, miss=0.
  - IDLE and GAME_OVER: combo/max_combo hold, lanes forced to L_IDLE, hit=0, miss=0. Notes and presses are ignored.
  - Leaving GAME_PLAY mid-window discards the pending note with no miss.
- Leaving and re-entering GAME_PLAY resumes with combo held (pause semantics).
- btn_q updates in all states, so a button held across the transition into GAME_PLAY gives no press.
- Reset mid-window: immediate return to the reset values above. No pulse is emitted.

Test Plan:
- Reset then GAME_PLAY; lane0 note_pulse at cycle 10, btn0 rise at cycle 15 -> hit=2'b01 at cycle 16 only, combo=1, max_combo=1, miss=0.
- Lane1 note_pulse at cycle 20, no press, WINDOW=12 -> miss pulse at cycle 33, combo 5->0, max_combo stays 5, hit=0. Press at cycle 32 (last window cycle) instead -> hit at 33.
- Both lanes note_pulse together, both buttons rise the same cycle -> hit=2'b11 for one cycle, combo+=2. Preload combo 254 -> 255; one further hit keeps 255.
- Lane0 hit and lane1 timeout judged the same cycle -> hit=2'b01 and miss=1 in the same cycle, combo=0.
- btn0 held high across 3 notes -> only the first note (press in its window) hits, next two miss. Press in L_IDLE -> no hit, no miss, combo unchanged.
- SONG_SELECT after combo=7/max=9 -> both 0 next cycle. rst pulsed mid-window in GAME_PLAY -> all outputs 0 immediately, no later miss.
